// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Register-write scoreboard for an in-order issue stage. It keeps one small
// counter per architectural register holding the number of in-flight writes
// to that register. Decode is stalled when a source operand has a pending
// write (RAW) or when the destination counter is already full.
//
// Parameters
//   MAXC : maximum in-flight writes tracked per register (1..7)
//   SCW  : width of the saturating stall-cycle counter
//
// Ports
//   clk_i          : clock, rising-edge active
//   rst_i          : asynchronous active-high reset
//   issue_valid_i  : decode presents an instruction this cycle
//   issue_wr_i     : reg-write mask, nonzero means issue_rd_i is written
//   issue_rd_i     : destination register of the issuing instruction
//   src_used_i     : bit0 = src1_i read, bit1 = src2_i read
//   src1_i/src2_i  : source register addresses
//   wb_valid_i     : a register write retires this cycle
//   wb_rd_i        : register written by the retiring write
//   flush_i        : squash, discards all in-flight writes
//   stall_o        : decode must hold (combinational)
//   issue_accept_o : issue taken this cycle (combinational)
//   busy_o         : bit n set while register n has in-flight writes
//   err_o          : sticky writeback-underflow flag
//   stall_cycles_o : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int MAXC = 3,
    parameter int SCW  = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           issue_valid_i,
    input  logic [1:0]     issue_wr_i,
    input  logic [3:0]     issue_rd_i,
    input  logic [1:0]     src_used_i,
    input  logic [3:0]     src1_i,
    input  logic [3:0]     src2_i,
    input  logic           wb_valid_i,
    input  logic [3:0]     wb_rd_i,
    input  logic           flush_i,
    output logic           stall_o,
    output logic           issue_accept_o,
    output logic [15:0]    busy_o,
    output logic           err_o,
    output logic [SCW-1:0] stall_cycles_o
);

    localparam int            CW      = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXC);

    logic [CW-1:0]  cnt_q [16];
    logic [CW-1:0]  cnt_d [16];
    logic           src1_haz;
    logic           src2_haz;
    logic           sat_haz;
    logic           inc_en;
    logic [15:0]    inc_vec;
    logic [15:0]    dec_vec;
    logic           err_set;
    logic           err_q;
    logic [SCW-1:0] stall_cnt_q;

    // Hazard detection looks only at the registered counts, so a writeback
    // in the same cycle cannot release a stall (there is no bypass path).
    always_comb begin
        src1_haz       = src_used_i[0] && (cnt_q[src1_i] != '0);
        src2_haz       = src_used_i[1] && (cnt_q[src2_i] != '0);
        sat_haz        = (issue_wr_i != 2'b00) && (cnt_q[issue_rd_i] == CNT_MAX);
        stall_o        = issue_valid_i && !flush_i && (src1_haz || src2_haz || sat_haz);
        issue_accept_o = issue_valid_i && !flush_i && !stall_o;
        inc_en         = issue_accept_o && (issue_wr_i != 2'b00);
    end

    // One-hot increment / decrement targets. A register hit by both in the
    // same cycle keeps its count; a decrement of an empty register is an
    // underflow and is reported instead of wrapping. Flush overrides all of it,
    // including the underflow report.
    always_comb begin
        inc_vec = inc_en     ? (16'h0001 << issue_rd_i) : 16'h0000;
        dec_vec = wb_valid_i ? (16'h0001 << wb_rd_i)    : 16'h0000;
        err_set = 1'b0;
        for (int n = 0; n < 16; n++) begin
            cnt_d[n] = cnt_q[n];
            if (flush_i) begin
                cnt_d[n] = '0;
            end else if (inc_vec[n] && !dec_vec[n]) begin
                cnt_d[n] = cnt_q[n] + CW'(1);
            end else if (dec_vec[n] && !inc_vec[n]) begin
                if (cnt_q[n] != '0) begin
                    cnt_d[n] = cnt_q[n] - CW'(1);
                end else begin
                    err_set = 1'b1;
                end
            end
        end
    end

    // Per-register in-flight counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int n = 0; n < 16; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 16; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Sticky underflow flag, only cleared by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    // Stalled-cycle counter that parks at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + SCW'(1);
        end
    end

    // Busy vector is a pure view of the registered counts.
    always_comb begin
        busy_o = '0;
        for (int n = 0; n < 16; n++) begin
            busy_o[n] = (cnt_q[n] != '0);
        end
    end

    assign err_o          = err_q;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Self-checking bench for hazard_scoreboard. A behavioural model keeps the
// number of outstanding writes per register as plain integers and derives
// stall/accept/busy/err/stall-count expectations from the scoreboard rules.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int MAXC   = 3;
    localparam int SCW    = 4;
    localparam int SC_MAX = (1 << SCW) - 1;

    logic           clk_i;
    logic           rst_i;
    logic           issue_valid_i;
    logic [1:0]     issue_wr_i;
    logic [3:0]     issue_rd_i;
    logic [1:0]     src_used_i;
    logic [3:0]     src1_i;
    logic [3:0]     src2_i;
    logic           wb_valid_i;
    logic [3:0]     wb_rd_i;
    logic           flush_i;
    logic           stall_o;
    logic           issue_accept_o;
    logic [15:0]    busy_o;
    logic           err_o;
    logic [SCW-1:0] stall_cycles_o;

    int nvec;
    int nerr;

    // Reference model state.
    int mcnt [16];
    bit merr;
    int mstall;

    hazard_scoreboard #(.MAXC(MAXC), .SCW(SCW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_wr_i     (issue_wr_i),
        .issue_rd_i     (issue_rd_i),
        .src_used_i     (src_used_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .issue_accept_o (issue_accept_o),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .stall_cycles_o (stall_cycles_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Model: decode must hold when a read source has writes pending or the
    // destination already has MAXC writes outstanding.
    function automatic bit m_stall();
        bit haz;
        haz = (src_used_i[0] && mcnt[src1_i] > 0) ||
              (src_used_i[1] && mcnt[src2_i] > 0) ||
              (issue_wr_i != 2'b00 && mcnt[issue_rd_i] == MAXC);
        return issue_valid_i && !flush_i && haz;
    endfunction

    function automatic bit m_accept();
        return issue_valid_i && !flush_i && !m_stall();
    endfunction

    function automatic logic [15:0] m_busy();
        logic [15:0] b;
        b = '0;
        for (int n = 0; n < 16; n++) begin
            if (mcnt[n] > 0) b[n] = 1'b1;
        end
        return b;
    endfunction

    task automatic m_reset();
        for (int n = 0; n < 16; n++) mcnt[n] = 0;
        merr   = 1'b0;
        mstall = 0;
    endtask

    task automatic drive(input logic v, input logic [1:0] wr, input logic [3:0] rd,
                         input logic [1:0] su, input logic [3:0] s1, input logic [3:0] s2,
                         input logic wv, input logic [3:0] wrd, input logic fl);
        issue_valid_i = v;
        issue_wr_i    = wr;
        issue_rd_i    = rd;
        src_used_i    = su;
        src1_i        = s1;
        src2_i        = s2;
        wb_valid_i    = wv;
        wb_rd_i       = wrd;
        flush_i       = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    // Advance one clock edge, moving the model forward with the inputs that
    // were held across the edge. An issue increment is applied before the
    // writeback is considered, so a same-register pair nets to zero.
    task automatic tick();
        int nc [16];
        bit ne;
        int ns;
        nc = mcnt;
        ne = merr;
        ns = mstall;
        if (flush_i) begin
            for (int n = 0; n < 16; n++) nc[n] = 0;
        end else begin
            if (m_accept() && issue_wr_i != 2'b00) nc[issue_rd_i] = nc[issue_rd_i] + 1;
            if (wb_valid_i) begin
                if (nc[wb_rd_i] > 0) nc[wb_rd_i] = nc[wb_rd_i] - 1;
                else ne = 1'b1;
            end
        end
        if (m_stall() && ns < SC_MAX) ns = ns + 1;
        @(posedge clk_i);
        mcnt   = nc;
        merr   = ne;
        mstall = ns;
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst_i = 1'b1;
        drive(1'b1, 2'b01, 4'd3, 2'b11, 4'd3, 4'd4, 1'b0, 4'd0, 1'b0);
        m_reset();
        nvec++;
        if (busy_o !== 16'h0000) begin
            nerr++; $display("[TB] FAIL reset_busy: got %h expected 0000", busy_o);
        end
        nvec++;
        if (err_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL reset_err: got %b expected 0", err_o);
        end
        nvec++;
        if (stall_cycles_o !== '0) begin
            nerr++; $display("[TB] FAIL reset_stallcnt: got %h expected 0", stall_cycles_o);
        end
        nvec++;
        if (stall_o !== 1'b0 || issue_accept_o !== 1'b1) begin
            nerr++; $display("[TB] FAIL reset_comb: got stall=%b acc=%b expected stall=0 acc=1",
                             stall_o, issue_accept_o);
        end
        idle();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_raw();
        $display("[TB] test_raw");
        drive(1'b1, 2'b11, 4'd5, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        nvec++;
        if (issue_accept_o !== 1'b1) begin
            nerr++; $display("[TB] FAIL raw_first_accept: got %b expected 1", issue_accept_o);
        end
        tick();
        // Dependent read with a same-cycle writeback: still stalls.
        drive(1'b1, 2'b00, 4'd0, 2'b01, 4'd5, 4'd0, 1'b1, 4'd5, 1'b0);
        nvec++;
        if (stall_o !== 1'b1 || issue_accept_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL raw_stall: got stall=%b acc=%b expected stall=1 acc=0",
                             stall_o, issue_accept_o);
        end
        nvec++;
        if (busy_o !== 16'h0020) begin
            nerr++; $display("[TB] FAIL raw_busy: got %h expected 0020", busy_o);
        end
        tick();
        drive(1'b1, 2'b00, 4'd0, 2'b01, 4'd5, 4'd0, 1'b0, 4'd0, 1'b0);
        nvec++;
        if (stall_o !== 1'b0 || busy_o !== 16'h0000) begin
            nerr++; $display("[TB] FAIL raw_release: got stall=%b busy=%h expected stall=0 busy=0000",
                             stall_o, busy_o);
        end
        tick();
        idle();
    endtask

    task automatic test_saturation();
        $display("[TB] test_saturation");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 4'd2, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
            nvec++;
            if (issue_accept_o !== 1'b1) begin
                nerr++; $display("[TB] FAIL sat_fill%0d: got acc=%b expected 1", i, issue_accept_o);
            end
            tick();
        end
        drive(1'b1, 2'b10, 4'd2, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        nvec++;
        if (stall_o !== 1'b1 || issue_accept_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL sat_full: got stall=%b acc=%b expected stall=1 acc=0",
                             stall_o, issue_accept_o);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd2, 1'b0);
            tick();
        end
        idle();
        nvec++;
        if (busy_o !== 16'h0000 || err_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL sat_drain: got busy=%h err=%b expected busy=0000 err=0",
                             busy_o, err_o);
        end
        nvec++;
        if (stall_cycles_o !== SCW'(mstall)) begin
            nerr++; $display("[TB] FAIL sat_stallcnt: got %0d expected %0d", stall_cycles_o, mstall);
        end
    endtask

    task automatic test_same_cycle();
        $display("[TB] test_same_cycle");
        drive(1'b1, 2'b01, 4'd7, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b1, 2'b01, 4'd7, 2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 1'b0);
        nvec++;
        if (issue_accept_o !== 1'b1) begin
            nerr++; $display("[TB] FAIL same_accept: got %b expected 1", issue_accept_o);
        end
        tick();
        idle();
        nvec++;
        if (busy_o !== 16'h0080 || err_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL same_hold: got busy=%h err=%b expected busy=0080 err=0",
                             busy_o, err_o);
        end
        drive(1'b0, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd7, 1'b0);
        tick();
        idle();
        nvec++;
        if (busy_o !== 16'h0000 || err_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL same_drain: got busy=%h err=%b expected busy=0000 err=0",
                             busy_o, err_o);
        end
    endtask

    task automatic test_flush();
        $display("[TB] test_flush");
        drive(1'b1, 2'b01, 4'd1, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        drive(1'b1, 2'b01, 4'd1, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        drive(1'b1, 2'b01, 4'd4, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        idle();
        nvec++;
        if (busy_o !== 16'h0012) begin
            nerr++; $display("[TB] FAIL flush_pre_busy: got %h expected 0012", busy_o);
        end
        // Flush with an issue and an empty-register writeback in the same cycle.
        drive(1'b1, 2'b01, 4'd1, 2'b01, 4'd4, 4'd0, 1'b1, 4'd9, 1'b1);
        nvec++;
        if (issue_accept_o !== 1'b0 || stall_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL flush_comb: got acc=%b stall=%b expected acc=0 stall=0",
                             issue_accept_o, stall_o);
        end
        tick();
        idle();
        nvec++;
        if (busy_o !== 16'h0000 || err_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL flush_clear: got busy=%h err=%b expected busy=0000 err=0",
                             busy_o, err_o);
        end
    endtask

    task automatic test_stall_saturation();
        $display("[TB] test_stall_saturation");
        drive(1'b1, 2'b01, 4'd3, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'b00, 4'd0, 2'b01, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0);
            nvec++;
            if (stall_o !== 1'b1 || stall_cycles_o !== SCW'(mstall)) begin
                nerr++; $display("[TB] FAIL stallcnt_step%0d: got stall=%b cnt=%0d expected stall=1 cnt=%0d",
                                 i, stall_o, stall_cycles_o, mstall);
            end
            tick();
        end
        idle();
        nvec++;
        if (stall_cycles_o !== 4'hF) begin
            nerr++; $display("[TB] FAIL stallcnt_sat: got %h expected f", stall_cycles_o);
        end
        drive(1'b0, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd3, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_underflow();
        $display("[TB] test_underflow");
        drive(1'b0, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b1, 4'd9, 1'b0);
        tick();
        idle();
        nvec++;
        if (err_o !== 1'b1 || busy_o !== 16'h0000) begin
            nerr++; $display("[TB] FAIL uflow_set: got err=%b busy=%h expected err=1 busy=0000",
                             err_o, busy_o);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            nvec++;
            if (err_o !== 1'b1) begin
                nerr++; $display("[TB] FAIL uflow_sticky%0d: got %b expected 1", i, err_o);
            end
        end
        rst_i = 1'b1;
        #1;
        m_reset();
        nvec++;
        if (err_o !== 1'b0) begin
            nerr++; $display("[TB] FAIL uflow_reset: got %b expected 0", err_o);
        end
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic [3:0] wrd;
        logic       wv;
        $display("[TB] test_random");
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 40 == 39) begin
                rst_i = 1'b1;
                #1;
                m_reset();
                rst_i = 1'b0;
            end
            wv  = ($urandom_range(0, 2) != 0);
            wrd = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 8) begin
                for (int k = 0; k < 4; k++) begin
                    if (mcnt[(int'(wrd) + k) % 4] > 0) begin
                        wrd = 4'((int'(wrd) + k) % 4);
                        break;
                    end
                end
            end
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                  wv, wrd, ($urandom_range(0, 15) == 0));
            nvec++;
            if (stall_o !== m_stall() || issue_accept_o !== m_accept()) begin
                nerr++; $display("[TB] FAIL rand_comb c%0d: got stall=%b acc=%b expected stall=%b acc=%b",
                                 cyc, stall_o, issue_accept_o, m_stall(), m_accept());
            end
            nvec++;
            if (busy_o !== m_busy()) begin
                nerr++; $display("[TB] FAIL rand_busy c%0d: got %h expected %h", cyc, busy_o, m_busy());
            end
            nvec++;
            if (err_o !== merr) begin
                nerr++; $display("[TB] FAIL rand_err c%0d: got %b expected %b", cyc, err_o, merr);
            end
            nvec++;
            if (stall_cycles_o !== SCW'(mstall)) begin
                nerr++; $display("[TB] FAIL rand_stallcnt c%0d: got %0d expected %0d",
                                 cyc, stall_cycles_o, mstall);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_i = 1'b1;
        m_reset();
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_raw();
        test_saturation();
        test_same_cycle();
        test_flush();
        test_stall_saturation();
        test_underflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MAXC, default 3, is the maximum in-flight writes tracked per register; legal range 1..7.
REQ-002 Parameter SCW, default 16, is the width of the stall-cycle counter.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 issue_valid_i  input  1  decode presents an instruction for issue this cycle.
REQ-006 issue_wr_i  input  2  reg_write mask of the issuing instruction; nonzero means it writes issue_rd_i.
REQ-007 issue_rd_i  input  4  destination register of the issuing instruction.
REQ-008 src_used_i  input  2  bit0 = src1_i is read, bit1 = src2_i is read.
REQ-009 src1_i, src2_i  input  4 each  source register addresses.
REQ-010 wb_valid_i  input  1  a register write retires this cycle.
REQ-011 wb_rd_i  input  4  register written by the retiring write.
REQ-012 flush_i  input  1  pipeline squash; all in-flight writes are discarded.
REQ-013 stall_o  output  1  decode must hold (combinational).
REQ-014 issue_accept_o  output  1  issue taken this cycle (combinational).
REQ-015 busy_o  output  16  bit n set when register n has one or more in-flight writes (registered state).
REQ-016 err_o  output  1  sticky underflow error.
REQ-017 stall_cycles_o  output  SCW  saturating count of stalled cycles.

Function
REQ-018 State: one counter per register, width ceil(log2(MAXC+1)), range 0..MAXC.
REQ-019 Source hazard: src1 hazard = src_used_i[0] and count[src1_i] != 0; src2 hazard is defined the same way with bit1.
REQ-020 Saturation hazard: issue_wr_i != 0 and count[issue_rd_i] == MAXC.
REQ-021 stall_o = issue_valid_i AND NOT flush_i AND (either source hazard OR saturation hazard).
REQ-022 Hazard checks use registered counts only; a same-cycle writeback does not remove a hazard (no bypass).
REQ-023 issue_accept_o = issue_valid_i AND NOT flush_i AND NOT stall_o.
REQ-024 An accepted issue with issue_wr_i != 0 increments count[issue_rd_i] at the next edge.
REQ-025 wb_valid_i decrements count[wb_rd_i] at the next edge.
REQ-026 If an accepted increment and a decrement target the same register in the same cycle, the count is unchanged.
REQ-027 If wb_valid_i targets a register whose count is 0 and there is no same-register increment, the count stays 0 and err_o sets.
REQ-028 err_o remains set until reset.
REQ-029 When flush_i is high, all counts clear to 0 at the next edge, regardless of same-cycle issue or wb.
REQ-030 A wb during flush never sets err_o.
REQ-031 stall_cycles_o increments by 1 on each edge where stall_o=1 and holds at all-ones once reached.
REQ-032 busy_o[n] = (count[n] != 0); it updates one cycle after the causing event.
REQ-033 Register 0 is tracked like any other register; no register is hardwired.
REQ-034 An issue with issue_wr_i == 0 never changes any count.
REQ-035 The latency from issue acceptance to a dependent stall is exactly one cycle.

Reset
REQ-036 On rst_i assertion, asynchronously: all counts = 0, busy_o = 16'h0000, err_o = 0, stall_cycles_o = 0.
REQ-037 During reset, stall_o and issue_accept_o follow the combinational rules using the zeroed state.
REQ-038 Reset mid-operation discards all in-flight tracking with no error flagged.

Verification
REQ-039 Issue wr=3, rd=5; next cycle issue src1=5, src_used=01 -> stall_o=1, busy_o=16'h0020; wb rd=5 -> stall_o=0 on the following cycle.
REQ-040 MAXC=3: three accepted issues to rd=2 with no wb -> count=3; fourth issue to rd=2 -> stall_o=1, issue_accept_o=0.
REQ-041 count[7]=1: same cycle accepted issue rd=7 and wb rd=7 -> count[7] stays 1, err_o=0.
REQ-042 wb rd=9 with count[9]=0 -> err_o=1, count[9]=0; err_o stays 1 for 10 further cycles, then clears on rst_i.
REQ-043 Counts for r1=2 and r4=1, then flush_i with a simultaneous issue rd=1 -> busy_o=16'h0000 next cycle, issue_accept_o=0 during flush.
REQ-044 SCW=4: hold a hazard for 20 cycles -> stall_cycles_o reaches 4'hF and stays there.
